// File: rtl/node0_feeder_pkg.sv
// Shared constants for the node0 feeder: FSM encodings, default sizing and
// the timeout counter width helper.
package node0_feeder_pkg;

  localparam int unsigned DefW     = 16;
  localparam int unsigned DefDepth = 4;
  localparam int unsigned DefTmo   = 1024;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;

  // Counter must hold TMO-1; keep at least one bit so TMO of 0..2 still elaborates.
  function automatic int unsigned cnt_width(input int unsigned tmo);
    return (tmo > 2) ? int'($clog2(tmo)) : 1;
  endfunction

endpackage

// File: rtl/node_arg_fifo.sv
// Synchronous argument FIFO; pointers carry one extra wrap bit so that
// full and empty are distinguishable without a separate count.
module node_arg_fifo
  import node0_feeder_pkg::*;
#(
  parameter int unsigned W     = 3 * DefW,
  parameter int unsigned DEPTH = DefDepth
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = (AW + 1)'(1);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wptr_q, wptr_d;
  logic [AW:0]  rptr_q, rptr_d;
  logic         do_push, do_pop;

  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty   = (wptr_q == rptr_q);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + PtrOne;
    if (do_pop)  rptr_d = rptr_q + PtrOne;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/node0_feeder.sv
// Job scheduler around a node0 core: queues argument triples, starts the
// node with a one-cycle ST pulse, and hands the result (or a timeout marker) downstream.
module node0_feeder
  import node0_feeder_pkg::*;
#(
  parameter int unsigned W     = DefW,
  parameter int unsigned DEPTH = DefDepth,
  parameter int unsigned TMO   = DefTmo
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         IVALID,
  output logic         IREADY,
  input  logic [W-1:0] A0,
  input  logic [W-1:0] A1,
  input  logic [W-1:0] A2,
  output logic         ST,
  output logic [W-1:0] IN0,
  output logic [W-1:0] IN1,
  output logic [W-1:0] IN2,
  input  logic         RD,
  input  logic [W-1:0] RES,
  output logic         OVALID,
  input  logic         OREADY,
  output logic [W-1:0] OUT,
  output logic         OERR,
  output logic         BUSY
);

  localparam int unsigned   CW      = cnt_width(TMO);
  localparam logic [CW-1:0] TmoLast = CW'((TMO > 0) ? TMO - 1 : 0);
  localparam logic [CW-1:0] CntOne  = CW'(1);

  logic [1:0]     state_q, state_d;
  logic           st_q, st_d;
  logic [W-1:0]   in0_q, in0_d, in1_q, in1_d, in2_q, in2_d;
  logic [W-1:0]   out_q, out_d;
  logic           oerr_q, oerr_d;
  logic           ovalid_q, ovalid_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [3*W-1:0] head;
  logic           fifo_full, fifo_empty, fifo_pop;
  logic           slot_free, timed_out;

  node_arg_fifo #(
    .W     (3 * W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (IVALID),
    .pop   (fifo_pop),
    .din   ({A0, A1, A2}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign fifo_pop  = (state_q == StIdle) && !fifo_empty;
  assign slot_free = !ovalid_q || OREADY;
  assign timed_out = (TMO != 0) && (cnt_q == TmoLast);

  always_comb begin
    state_d  = state_q;
    st_d     = st_q;
    in0_d    = in0_q;
    in1_d    = in1_q;
    in2_d    = in2_q;
    out_d    = out_q;
    oerr_d   = oerr_q;
    cnt_d    = cnt_q;
    ovalid_d = ovalid_q && !OREADY;
    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          {in0_d, in1_d, in2_d} = head;
          st_d    = 1'b1;
          state_d = StStart;
        end
      end
      StStart: begin
        st_d    = 1'b0;
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        // A real result wins over a timeout that expires on the same edge.
        if ((RD || timed_out) && slot_free) begin
          out_d    = RD ? RES : '1;
          oerr_d   = !RD;
          ovalid_d = 1'b1;
          state_d  = StIdle;
        end else if ((TMO != 0) && !timed_out && slot_free) begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= StIdle;
      st_q     <= 1'b0;
      in0_q    <= '0;
      in1_q    <= '0;
      in2_q    <= '0;
      out_q    <= '0;
      oerr_q   <= 1'b0;
      ovalid_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      st_q     <= st_d;
      in0_q    <= in0_d;
      in1_q    <= in1_d;
      in2_q    <= in2_d;
      out_q    <= out_d;
      oerr_q   <= oerr_d;
      ovalid_q <= ovalid_d;
      cnt_q    <= cnt_d;
    end
  end

  assign IREADY = !fifo_full;
  assign ST     = st_q;
  assign IN0    = in0_q;
  assign IN1    = in1_q;
  assign IN2    = in2_q;
  assign OVALID = ovalid_q;
  assign OUT    = out_q;
  assign OERR   = oerr_q;
  assign BUSY   = (state_q != StIdle) || !fifo_empty;

endmodule
